// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment encoding constants and helper
package seg7_pkg;

    // gfedcba, active low; index is the hex nibble value
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] seg7_enc(input logic [3:0] nibble);
        return SEG7_LUT[nibble];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational nibble to active-low segment decoder with blanking
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blanking overrides the glyph so the digit is fully dark
    assign seg_o = blank_i ? SEG_OFF : seg7_enc(nibble_i);

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - static and scanned hex display driver with LZ blanking and blink
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BLINK_DIV  = 250
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic [4*NUM_DIGITS-1:0]   data_i,
    input  logic                      blank_lz_i,
    input  logic [NUM_DIGITS-1:0]     blink_mask_i,
    output logic [7*NUM_DIGITS-1:0]   hex_o,
    output logic [6:0]                seg_o,
    output logic [NUM_DIGITS-1:0]     an_o
);

    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int SW = $clog2(NUM_DIGITS + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan_display: NUM_DIGITS must be 1..8");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("seg7_scan_display: CLK_DIV must be >= 1");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("seg7_scan_display: BLINK_DIV must be >= 1");
    end

    logic [4*NUM_DIGITS-1:0] data_q;
    logic [PW-1:0]           pre_q;
    logic [SW-1:0]           scan_idx_q;
    logic [BW-1:0]           blink_cnt_q;
    logic                    blink_phase_q;
    logic [7*NUM_DIGITS-1:0] hex_q;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;

    logic                    tick;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   lz;
    logic [NUM_DIGITS-1:0]   blank;
    logic [6:0]              pat [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] pat_flat;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   an_d;

    assign tick = (pre_q == PRE_LAST);

    // Leading-zero detect: walk from the top digit down while every nibble seen is zero
    always_comb begin
        zero_above = 1'b1;
        lz         = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (data_q[4*k +: 4] == 4'h0);
            lz[k]      = blank_lz_i & (k != 0) & zero_above;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        assign blank[k] = lz[k] | (blink_mask_i[k] & blink_phase_q);

        seg7_decode u_dec (
            .nibble_i (data_q[4*k +: 4]),
            .blank_i  (blank[k]),
            .seg_o    (pat[k])
        );

        assign pat_flat[7*k +: 7] = pat[k];
    end

    // Scan mux: pick the active digit's pattern and its enable without shifting by a wide index
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx_q == SW'(k)) begin
                seg_d    = pat[k];
                an_d[k]  = 1'b0;
            end
        end
    end

    // Display register: captures the new value only when load_i is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    // Prescaler, scan index and blink timebase all advance off the same tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q         <= '0;
            scan_idx_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                scan_idx_q <= (scan_idx_q == SCAN_LAST) ? '0 : scan_idx_q + SW'(1);
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BW'(1);
                end
            end
        end
    end

    // Output registers: static and scanned views come from the same decode, so they never disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q <= '1;
            seg_q <= SEG_OFF;
            an_q  <= '1;
        end else begin
            hex_q <= pat_flat;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign hex_o = hex_q;
    assign seg_o = seg_q;
    assign an_o  = an_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - self-checking bench for seg7_scan_display
module tb_seg7_scan_display;

    localparam int CLKD  = 2;
    localparam int BLNKD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        load     = 1'b0;
    logic [15:0] data     = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  mask     = '0;
    logic [27:0] hex;
    logic [6:0]  seg;
    logic [3:0]  an;

    logic        load1     = 1'b0;
    logic [3:0]  data1     = '0;
    logic        blank_lz1 = 1'b0;
    logic [0:0]  mask1     = '0;
    logic [6:0]  hex1;
    logic [6:0]  seg1;
    logic [0:0]  an1;

    seg7_scan_display #(.NUM_DIGITS(4), .CLK_DIV(CLKD), .BLINK_DIV(BLNKD)) dut (
        .clk(clk), .rst_n(rst_n), .load_i(load), .data_i(data), .blank_lz_i(blank_lz),
        .blink_mask_i(mask), .hex_o(hex), .seg_o(seg), .an_o(an)
    );

    seg7_scan_display #(.NUM_DIGITS(1), .CLK_DIV(1), .BLINK_DIV(BLNKD)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_i(load1), .data_i(data1), .blank_lz_i(blank_lz1),
        .blink_mask_i(mask1), .hex_o(hex1), .seg_o(seg1), .an_o(an1)
    );

    logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pattern of digit k from the display rules
    function automatic logic [6:0] digit_pat(input int k, input logic [15:0] d, input logic lzen,
                                             input logic [3:0] m, input int ph);
        if (lzen && k != 0 && (d >> (4 * k)) == 16'h0) return 7'h7F;
        if (m[k] && ph != 0) return 7'h7F;
        return lut[d[4*k +: 4]];
    endfunction

    // Model: outputs after edge n depend on the data held before it and on floor(n/CLK_DIV) ticks
    int          n     = 0;
    logic [15:0] mdata = '0;
    logic [3:0]  mdata1 = '0;
    logic [27:0] exp_hex = '1;
    logic [6:0]  exp_seg = 7'h7F;
    logic [3:0]  exp_an  = 4'hF;
    logic [6:0]  exp_seg1 = 7'h7F;
    logic [0:0]  exp_an1  = 1'b1;
    logic        run_chk  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; mdata = '0; mdata1 = '0;
            exp_hex = '1; exp_seg = 7'h7F; exp_an = 4'hF;
            exp_seg1 = 7'h7F; exp_an1 = 1'b1;
        end else begin
            int ticks, idx, ph;
            ticks = n / CLKD;
            idx   = ticks % 4;
            ph    = (ticks / BLNKD) % 2;
            for (int k = 0; k < 4; k++) exp_hex[7*k +: 7] = digit_pat(k, mdata, blank_lz, mask, ph);
            exp_seg = exp_hex[7*idx +: 7];
            exp_an  = 4'hF;
            exp_an[idx] = 1'b0;
            exp_seg1 = lut[mdata1];
            exp_an1  = 1'b0;
            if (load) mdata = data;
            if (load1) mdata1 = data1;
            n++;
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            chk("cyc_hex", 32'(hex), 32'(exp_hex));
            chk("cyc_seg", 32'(seg), 32'(exp_seg));
            chk("cyc_an", 32'(an), 32'(exp_an));
            chk("cyc_seg1", 32'(seg1), 32'(exp_seg1));
            chk("cyc_hex1", 32'(hex1), 32'(exp_seg1));
            chk("cyc_an1", 32'(an1), 32'(exp_an1));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [6:0] want;
    int seen00, seen7f;

    initial begin
        // 1: reset state and release
        repeat (2) @(posedge clk);
        #1 run_chk = 1'b1;
        step();
        #1;
        chk("rst_hex", 32'(hex), 32'h0FFFFFFF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_an", 32'(an), 32'hE);
        chk("first_an1", 32'(an1), 32'h0);
        #1;

        // 2: plain load and scan order
        data = 16'h12AF; load = 1'b1;
        step();
        load = 1'b0;
        #1 chk("hex_n1_old", 32'(hex), 32'({4{7'h40}}));
        step();
        #1 chk("hex_12af", 32'(hex), 32'({7'h79, 7'h24, 7'h08, 7'h0E}));
        for (int i = 0; i < 12; i++) begin
            step();
            #1;
            case (an)
                4'hE: want = 7'h0E;
                4'hD: want = 7'h08;
                4'hB: want = 7'h24;
                4'h7: want = 7'h79;
                default: want = 7'h7F;
            endcase
            chk("scan_an_onehot", 32'(an == 4'hE || an == 4'hD || an == 4'hB || an == 4'h7), 32'd1);
            chk("scan_seg_pair", 32'(seg), 32'(want));
        end

        // 3: leading-zero blanking
        blank_lz = 1'b1; data = 16'h0040; load = 1'b1;
        step();
        load = 1'b0;
        step();
        #1 chk("lz_0040", 32'(hex), 32'({7'h7F, 7'h7F, 7'h19, 7'h40}));
        data = 16'h0000; load = 1'b1;
        step();
        load = 1'b0;
        step();
        #1 chk("lz_0000", 32'(hex), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

        // 4: blink on digit 1 only
        blank_lz = 1'b0; mask = 4'b0010; data = 16'h8888; load = 1'b1;
        step();
        load = 1'b0;
        step();
        seen00 = 0; seen7f = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            #1;
            if (hex[13:7] == 7'h00) seen00++;
            if (hex[13:7] == 7'h7F) seen7f++;
            chk("blink_others", 32'({hex[27:14], hex[6:0]}), 32'h0);
        end
        chk("blink_saw_on", 32'(seen00 > 0), 32'd1);
        chk("blink_saw_off", 32'(seen7f > 0), 32'd1);

        // 5: load landing on a tick edge
        mask = 4'b0000; data = 16'h0000; load = 1'b1;
        step();
        load = 1'b0;
        step();
        for (int i = 0; i < 4 && (n % CLKD) != CLKD - 1; i++) step();
        chk("tick_align", 32'(n % CLKD), 32'(CLKD - 1));
        data = 16'hFFFF; load = 1'b1;
        step();
        load = 1'b0;
        #1 chk("tick_hex_old", 32'(hex), 32'({4{7'h40}}));
        step();
        #1;
        chk("tick_seg_new", 32'(seg), 32'h0E);
        chk("tick_hex_new", 32'(hex), 32'({4{7'h0E}}));

        // 6: single-digit instance with tick every cycle
        data1 = 4'h5; load1 = 1'b1;
        step();
        load1 = 1'b0;
        #1 chk("one_seg_old", 32'(seg1), 32'h40);
        step();
        #1;
        chk("one_seg_new", 32'(seg1), 32'h12);
        chk("one_an", 32'(an1), 32'h0);

        // 1b: asynchronous reset mid-scan
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_hex", 32'(hex), 32'h0FFFFFFF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_an1", 32'(an1), 32'h1);
        step();
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("mid_rel_an", 32'(an), 32'hE);
        chk("mid_rel_hex", 32'(hex), 32'({4{7'h40}}));
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
